axi_lite_mem_arbiter: RTL

// - Shares one AXI4-Lite slave (the memory block) among NUM_M AXI4-Lite masters (DMA engine, AES core, CPU).
// - Round-robin, one transaction (write or read) outstanding at a time.
// - Registers the granted address so the slave sees a stable awaddr/araddr for the whole transaction.
// - Sits between the masters and the memory; data channels pass through under the grant.

---
 rtl/axi_lite_pkg.sv | 19 +
 rtl/axi_lite_mem_arbiter_rr.sv | 48 ++++
 rtl/axi_lite_mem_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite memory arbiter.
package axi_lite_pkg;

    // Arbiter FSM: IDLE picks a master, WR/WRESP carry a write, RD/RDATA carry a read.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WRESP = 3'd2,
        RD    = 3'd3,
        RDATA = 3'd4
    } arb_state_e;

    // Kind of transaction chosen for the granted master.
    typedef enum logic {
        TXN_WR = 1'b0,
        TXN_RD = 1'b1
    } txn_kind_e;

endpackage

// File: rtl/axi_lite_mem_arbiter_rr.sv
// Round-robin picker: grant is the first requester at or after the pointer.
// The pointer moves to (owner + 1) mod N when the current transaction retires.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    input  logic         advance,
    input  logic [N-1:0] owner,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  ptr_q;
    logic [PW-1:0]  ptr_d;
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   first_rot;
    logic [2*N-1:0] grant_dbl;

    // Rotate requests so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        req_dbl   = {req, req} >> ptr_q;
        req_rot   = req_dbl[N-1:0];
        first_rot = req_rot & (~req_rot + {{(N-1){1'b0}}, 1'b1});
        grant_dbl = {first_rot, first_rot} << ptr_q;
        grant     = grant_dbl[2*N-1:N];
    end

    // Next pointer: one past the master whose transaction just finished.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            for (int i = 0; i < N; i++) begin
                if (owner[i]) ptr_d = PW'((i + 1) % N);
            end
        end
    end

    // Pointer register, master 0 has priority after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI4-Lite memory slave among NUM_M masters, one transaction at a time.
// Handshake rule on every channel: a beat transfers on the rising edge where valid
// and ready are both high; valid, once raised, must stay high until that edge.
module axi_lite_mem_arbiter
    import axi_lite_pkg::*;
#(
    parameter int NUM_M      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_M-1:0]            m_awvalid,
    input  logic [NUM_M*ADDR_WIDTH-1:0] m_awaddr,
    output logic [NUM_M-1:0]            m_awready,
    input  logic [NUM_M-1:0]            m_wvalid,
    input  logic [NUM_M*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_M-1:0]            m_wready,
    output logic [NUM_M-1:0]            m_bvalid,
    input  logic [NUM_M-1:0]            m_bready,
    input  logic [NUM_M-1:0]            m_arvalid,
    input  logic [NUM_M*ADDR_WIDTH-1:0] m_araddr,
    output logic [NUM_M-1:0]            m_arready,
    output logic [NUM_M-1:0]            m_rvalid,
    output logic [NUM_M*DATA_WIDTH-1:0] m_rdata,
    input  logic [NUM_M-1:0]            m_rready,
    output logic                        s_awvalid,
    output logic [ADDR_WIDTH-1:0]       s_awaddr,
    input  logic                        s_awready,
    output logic                        s_wvalid,
    output logic [DATA_WIDTH-1:0]       s_wdata,
    input  logic                        s_wready,
    input  logic                        s_bvalid,
    output logic                        s_bready,
    output logic                        s_arvalid,
    output logic [ADDR_WIDTH-1:0]       s_araddr,
    input  logic                        s_arready,
    input  logic                        s_rvalid,
    input  logic [DATA_WIDTH-1:0]       s_rdata,
    output logic                        s_rready,
    output logic [NUM_M-1:0]            grant,
    output logic                        busy
);

    arb_state_e            state_q, state_d;
    txn_kind_e             kind_d;
    logic [NUM_M-1:0]      grant_q, grant_d;
    logic [NUM_M-1:0]      req, arb_grant;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                  advance;
    logic                  pick_aw;
    logic [ADDR_WIDTH-1:0] pick_awaddr, pick_araddr;
    logic                  sel_wvalid, sel_bready, sel_rready;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign req   = m_awvalid | m_arvalid;
    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

    rr_arbiter #(.N(NUM_M)) u_rr (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .advance (advance),
        .owner   (grant_q),
        .grant   (arb_grant)
    );

    // Request fields of the master the round-robin picker would grant now.
    always_comb begin
        pick_aw     = 1'b0;
        pick_awaddr = '0;
        pick_araddr = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (arb_grant[i]) begin
                pick_aw     = m_awvalid[i];
                pick_awaddr = m_awaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                pick_araddr = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Inbound signals of the currently granted master.
    always_comb begin
        sel_wvalid = |(m_wvalid & grant_q);
        sel_bready = |(m_bready & grant_q);
        sel_rready = |(m_rready & grant_q);
        sel_wdata  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            sel_wdata = sel_wdata | (m_wdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_q[i]}});
        end
    end

    // Next state and channel routing; a write wins over a read from the same master.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        advance   = 1'b0;
        kind_d    = pick_aw ? TXN_WR : TXN_RD;
        s_awvalid = 1'b0;
        s_awaddr  = addr_q;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_bready  = 1'b0;
        s_arvalid = 1'b0;
        s_araddr  = addr_q;
        s_rready  = 1'b0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d   = arb_grant;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (kind_d == TXN_WR) begin
                        addr_d  = pick_awaddr;
                        state_d = WR;
                    end else begin
                        addr_d  = pick_araddr;
                        state_d = RD;
                    end
                end
            end
            WR: begin
                s_awvalid = !aw_done_q;
                s_wvalid  = sel_wvalid & !w_done_q;
                s_wdata   = sel_wdata;
                m_awready = grant_q & {NUM_M{s_awready & !aw_done_q}};
                m_wready  = grant_q & {NUM_M{s_wready & !w_done_q}};
                aw_done_d = aw_done_q | (!aw_done_q & s_awready);
                w_done_d  = w_done_q | (sel_wvalid & !w_done_q & s_wready);
                if (aw_done_d && w_done_d) state_d = WRESP;
            end
            WRESP: begin
                m_bvalid = grant_q & {NUM_M{s_bvalid}};
                s_bready = sel_bready;
                if (s_bvalid && sel_bready) begin
                    state_d = IDLE;
                    grant_d = '0;
                    advance = 1'b1;
                end
            end
            RD: begin
                s_arvalid = 1'b1;
                m_arready = grant_q & {NUM_M{s_arready}};
                if (s_arready) state_d = RDATA;
            end
            RDATA: begin
                m_rvalid = grant_q & {NUM_M{s_rvalid}};
                s_rready = sel_rready;
                for (int i = 0; i < NUM_M; i++) begin
                    if (grant_q[i]) m_rdata[i*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
                end
                if (s_rvalid && sel_rready) begin
                    state_d = IDLE;
                    grant_d = '0;
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, grant, held address and write progress flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            addr_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule
